// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-ported memory with fixed read latency.
// Requester 0 is instruction fetch, requester 1 is load/store. Writes finish
// in the grant cycle; a read blocks further grants until its data returns.
module mem_arbiter #(
  parameter int AW  = 12,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] LAT_C = 3'(LAT);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       owner, owner_nx;
  logic       prio, prio_nx;
  logic       open;
  logic       win;

  // Read data is broadcast; only the rvalid strobes are qualified.
  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

  // State, latency counter, read owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      owner <= owner_nx;
      prio  <= prio_nx;
    end
  end

  // Arbitration, command mux, read-return strobes and next-state logic.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    owner_nx  = owner;
    prio_nx   = prio;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;

    // The data-return cycle of a read doubles as an IDLE cycle, which is
    // what allows back-to-back reads every LAT cycles.
    open = (state == IDLE) || (cnt == 3'd1);
    win  = (req0 && req1) ? prio : req1;

    if (state == WAIT) begin
      if (cnt == 3'd1) begin
        rvalid0  = ~owner;
        rvalid1  = owner;
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        busy   = 1'b1;
        cnt_nx = cnt - 3'd1;
      end
    end

    if (open && (req0 || req1)) begin
      gnt0      = ~win;
      gnt1      = win;
      mem_en    = 1'b1;
      mem_we    = win ? we1 : we0;
      mem_addr  = win ? addr1 : addr0;
      mem_wdata = win ? wdata1 : wdata0;
      prio_nx   = ~win;
      if (!mem_we) begin
        state_nx = WAIT;
        cnt_nx   = LAT_C;
        owner_nx = win;
      end
    end

    // Outputs are forced quiet for the whole reset cycle, not just after it.
    if (rst) begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      rvalid0 = 1'b0;
      rvalid1 = 1'b0;
      mem_en  = 1'b0;
      mem_we  = 1'b0;
      busy    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 uses LAT=2, instance 1 LAT=1.
// Stimulus pushes expected grants/read returns; a monitor pops and compares.
module tb_mem_arbiter;

  typedef struct {
    int          cyc;
    logic [1:0]  who;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [1:0]  req0_v = '0, req1_v = '0, we0_v = '0, we1_v = '0;
  logic [11:0] addr0_v [2];
  logic [11:0] addr1_v [2];
  logic [31:0] wd0_v [2];
  logic [31:0] wd1_v [2];
  logic [1:0]  gnt0_v, gnt1_v, rv0_v, rv1_v, en_v, mwe_v, busy_v;
  logic [11:0] maddr_v [2];
  logic [31:0] mwd_v [2];
  logic [31:0] rd0_v [2];
  logic [31:0] rd1_v [2];
  logic [31:0] pa0 = '0, pa1 = '0, rdb = '0;
  logic [31:0] mem [4096];

  ev_t gq [2][$];
  ev_t rq [2][$];

  mem_arbiter #(.AW(12), .DW(32), .LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_v[0]), .req1(req1_v[0]), .we0(we0_v[0]), .we1(we1_v[0]),
    .addr0(addr0_v[0]), .addr1(addr1_v[0]), .wdata0(wd0_v[0]), .wdata1(wd1_v[0]),
    .gnt0(gnt0_v[0]), .gnt1(gnt1_v[0]), .rvalid0(rv0_v[0]), .rvalid1(rv1_v[0]),
    .rdata0(rd0_v[0]), .rdata1(rd1_v[0]), .mem_en(en_v[0]), .mem_we(mwe_v[0]),
    .mem_addr(maddr_v[0]), .mem_wdata(mwd_v[0]), .mem_rdata(pa1), .busy(busy_v[0])
  );

  mem_arbiter #(.AW(12), .DW(32), .LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_v[1]), .req1(req1_v[1]), .we0(we0_v[1]), .we1(we1_v[1]),
    .addr0(addr0_v[1]), .addr1(addr1_v[1]), .wdata0(wd0_v[1]), .wdata1(wd1_v[1]),
    .gnt0(gnt0_v[1]), .gnt1(gnt1_v[1]), .rvalid0(rv0_v[1]), .rvalid1(rv1_v[1]),
    .rdata0(rd0_v[1]), .rdata1(rd1_v[1]), .mem_en(en_v[1]), .mem_we(mwe_v[1]),
    .mem_addr(maddr_v[1]), .mem_wdata(mwd_v[1]), .mem_rdata(rdb), .busy(busy_v[1])
  );

  always #5 clk = ~clk;

  // Cycle index used to time-stamp expected events.
  always @(posedge clk) cyc = cyc + 1;

  // Memory models: 2-stage read pipeline with writable array, and a 1-stage
  // read-only model returning C0DE_0000 | addr.
  always @(posedge clk) begin
    if (en_v[0] && mwe_v[0]) mem[maddr_v[0]] <= mwd_v[0];
    pa0 <= (en_v[0] && !mwe_v[0]) ? mem[maddr_v[0]] : 32'h0;
    pa1 <= pa0;
    rdb <= (en_v[1] && !mwe_v[1]) ? (32'hC0DE_0000 | {20'h0, maddr_v[1]}) : 32'h0;
  end

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expected events whenever a DUT shows a grant or rvalid.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ev_t e;
      logic [1:0] g;
      logic [1:0] r;
      g = {gnt1_v[d], gnt0_v[d]};
      r = {rv1_v[d], rv0_v[d]};
      while (gq[d].size() > 0 && gq[d][0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL grant_missing dut%0d: got none, expected grant at cycle %0d", d, gq[d][0].cyc);
        void'(gq[d].pop_front());
      end
      while (rq[d].size() > 0 && rq[d][0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL rvalid_missing dut%0d: got none, expected rvalid at cycle %0d", d, rq[d][0].cyc);
        void'(rq[d].pop_front());
      end
      if (g != 2'b00) begin
        if (gq[d].size() > 0 && gq[d][0].cyc == cyc) begin
          e = gq[d].pop_front();
          cmp($sformatf("grant_dut%0d", d),
              {32'(cyc), g, en_v[d], mwe_v[d], maddr_v[d], mwd_v[d]},
              {32'(e.cyc), e.who, 1'b1, e.we, e.addr, e.data});
        end else begin
          n_cmp++; n_bad++;
          $display("FAIL grant_unexpected dut%0d: got gnt=%b at cycle %0d, expected none", d, g, cyc);
        end
      end else begin
        cmp($sformatf("idle_cmd_dut%0d", d), {en_v[d], mwe_v[d]}, 2'b00);
      end
      if (r != 2'b00) begin
        if (rq[d].size() > 0 && rq[d][0].cyc == cyc) begin
          e = rq[d].pop_front();
          cmp($sformatf("rvalid_dut%0d", d),
              {32'(cyc), r, rd0_v[d], rd1_v[d]},
              {32'(e.cyc), e.who, e.data, e.data});
        end else begin
          n_cmp++; n_bad++;
          $display("FAIL rvalid_unexpected dut%0d: got rvalid=%b at cycle %0d, expected none", d, r, cyc);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1);
    req0_v[0] = r0; we0_v[0] = w0; addr0_v[0] = a0; wd0_v[0] = d0;
    req1_v[0] = r1; we1_v[0] = w1; addr1_v[0] = a1; wd1_v[0] = d1;
  endtask

  task automatic push_g(input int d, input logic [1:0] who, input logic we,
                        input logic [11:0] a, input logic [31:0] w);
    ev_t e;
    e.cyc = cyc; e.who = who; e.we = we; e.addr = a; e.data = w;
    gq[d].push_back(e);
  endtask

  task automatic push_r(input int d, input logic [1:0] who, input logic [31:0] data, input int lat);
    ev_t e;
    e.cyc = cyc + lat; e.who = who; e.we = 1'b0; e.addr = '0; e.data = data;
    rq[d].push_back(e);
  endtask

  task automatic settle(input logic ba, input logic bb);
    @(negedge clk);
    cmp("busy_dut0", busy_v[0], ba);
    cmp("busy_dut1", busy_v[1], bb);
  endtask

  task automatic chk_reset();
    cmp("reset_outputs", {gnt0_v, gnt1_v, rv0_v, rv1_v, en_v, mwe_v, busy_v}, 14'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[12'h010] = 32'hDEAD_BEEF;
    for (int d = 0; d < 2; d++) begin
      addr0_v[d] = '0; addr1_v[d] = '0; wd0_v[d] = '0; wd1_v[d] = '0;
    end

    // Reset with requests pending: nothing may be granted.
    next(); rst = 1'b1; set_a(1, 0, 12'h010, 0, 1, 0, 12'h020, 0); settle(0, 0); chk_reset();
    next(); settle(0, 0); chk_reset();

    // Single read, request dropped while waiting; data still returned.
    next(); rst = 1'b0; set_a(1, 0, 12'h010, 0, 0, 0, 0, 0);
    push_g(0, 2'b01, 0, 12'h010, 0); push_r(0, 2'b01, 32'hDEAD_BEEF, 2); settle(0, 0);
    next(); set_a(0, 0, 0, 0, 0, 0, 0, 0); settle(1, 0);
    next(); settle(0, 0);

    // Three consecutive writes from requester 1.
    for (int k = 0; k < 3; k++) begin
      next(); set_a(0, 0, 0, 0, 1, 1, 12'h020, 32'h5);
      push_g(0, 2'b10, 1, 12'h020, 32'h5); settle(0, 0);
    end
    next(); set_a(0, 0, 0, 0, 0, 0, 0, 0); settle(0, 0);

    // From reset, both requesters read continuously: grants alternate.
    next(); rst = 1'b1; settle(0, 0); chk_reset();
    for (int k = 0; k < 4; k++) begin
      next();
      if (k == 0) begin
        rst = 1'b0; set_a(1, 0, 12'h100, 0, 1, 0, 12'h200, 0);
      end
      if (k % 2 == 0) begin
        push_g(0, 2'b01, 0, 12'h100, 0); push_r(0, 2'b01, 32'hC0DE_0100, 2);
      end else begin
        push_g(0, 2'b10, 0, 12'h200, 0); push_r(0, 2'b10, 32'hC0DE_0200, 2);
      end
      settle(0, 0);
      next(); settle(1, 0);
    end
    next(); set_a(0, 0, 0, 0, 0, 0, 0, 0); settle(0, 0);

    // rvalid0 coincides with a grant to requester 1.
    next(); set_a(1, 0, 12'h030, 0, 0, 0, 0, 0);
    push_g(0, 2'b01, 0, 12'h030, 0); push_r(0, 2'b01, 32'hC0DE_0030, 2); settle(0, 0);
    next(); set_a(1, 0, 12'h030, 0, 1, 0, 12'h040, 0); settle(1, 0);
    next(); push_g(0, 2'b10, 0, 12'h040, 0); push_r(0, 2'b10, 32'hC0DE_0040, 2); settle(0, 0);
    next(); set_a(0, 0, 0, 0, 0, 0, 0, 0); settle(1, 0);
    next(); settle(0, 0);

    // Reset mid-read abandons it; requester 0 wins first after release.
    next(); set_a(1, 0, 12'h050, 0, 0, 0, 0, 0);
    push_g(0, 2'b01, 0, 12'h050, 0); settle(0, 0);
    next(); rst = 1'b1; set_a(1, 0, 12'h050, 0, 1, 0, 12'h060, 0); settle(0, 0); chk_reset();
    next(); rst = 1'b0;
    push_g(0, 2'b01, 0, 12'h050, 0); push_r(0, 2'b01, 32'hC0DE_0050, 2); settle(0, 0);
    next(); set_a(0, 0, 0, 0, 0, 0, 0, 0); settle(1, 0);
    next(); settle(0, 0);
    next(); settle(0, 0);

    // LAT=1 instance: back-to-back reads every cycle, never busy.
    for (int k = 0; k < 5; k++) begin
      next(); req0_v[1] = 1'b1; addr0_v[1] = 12'(k);
      push_g(1, 2'b01, 0, 12'(k), 0); push_r(1, 2'b01, 32'hC0DE_0000 | 32'(k), 1);
      settle(0, 0);
    end
    next(); req0_v[1] = 1'b0; settle(0, 0);
    next(); settle(0, 0);
    next(); settle(0, 0);

    cmp("grant_queue_drained_dut0", gq[0].size(), 0);
    cmp("grant_queue_drained_dut1", gq[1].size(), 0);
    cmp("rvalid_queue_drained_dut0", rq[0].size(), 0);
    cmp("rvalid_queue_drained_dut1", rq[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
